// File: rtl/alu_sweep_sequencer.sv
// Stimulus/capture engine for the 8-bit board ALU: latches one operand set, steps the ALU
// through all 16 {mode_select, control_line} operations and streams each sampled result out.
module alu_sweep_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c_in,
    output logic [2:0]       alu_control_line,
    output logic             alu_mode_select,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_index,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StDrive, StPresent, StDone} state_e;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [3:0]       ridx_q, ridx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StDrive;
            StDrive:   if (cnt_q == 8'd0) state_d = StPresent;
            StPresent: if (res_ready) state_d = (idx_q == 4'hF) ? StDone : StDrive;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ridx_d  = ridx_q;
        data_d  = data_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (start) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    cin_d = op_cin;
                    idx_d = 4'd0;
                    cnt_d = HoldLoad;
                end
            end
            StDrive: begin
                if (cnt_q == 8'd0) begin
                    data_d  = alu_out;
                    cout_d  = alu_c_out;
                    ridx_d  = idx_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StPresent: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    if (idx_q != 4'hF) begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = HoldLoad;
                    end
                end
            end
            StDone:  valid_d = 1'b0;
            default: valid_d = 1'b0;
        endcase
        // Status flags are registered off the next state so they line up with it.
        busy_d = (state_d == StDrive) || (state_d == StPresent);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            ridx_q  <= 4'd0;
            data_q  <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ridx_q  <= ridx_d;
            data_q  <= data_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign alu_a            = a_q;
    assign alu_b            = b_q;
    assign alu_c_in         = cin_q;
    assign alu_mode_select  = idx_q[3];
    assign alu_control_line = idx_q[2:0];
    assign res_valid        = valid_q;
    assign res_index        = ridx_q;
    assign res_data         = data_q;
    assign res_cout         = cout_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Bench for alu_sweep_sequencer: an XOR stub ALU on a HOLD_CYCLES=4 instance and a
// behavioural ALU on a HOLD_CYCLES=1 instance, checked against a per-sweep reference model.
module tb_alu_sweep_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st, rdy, sel;
    logic [7:0] op_a, op_b;
    logic       op_cin;
    int         n_cmp, n_bad;

    logic       start0, start1, ready0, ready1;
    logic [7:0] a0, b0, aout0, data0, a1, b1, aout1, data1;
    logic       cin0, mode0, cin_ret0, valid0, cout0, busy0, done0;
    logic       cin1, mode1, cin_ret1, valid1, cout1, busy1, done1;
    logic [2:0] ctrl0, ctrl1;
    logic [3:0] idx0, idx1;

    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic [3:0] op);
        logic [8:0] r;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b0, a} + 9'd1;
            4'd3:    r = {1'b0, a} - 9'd1;
            4'd4:    r = {1'b0, a} + {8'h00, cin};
            4'd5:    r = {1'b0, b} + {8'h00, cin};
            4'd6:    r = {a, cin};
            4'd7:    r = {1'b0, a} + {1'b0, b};
            4'd8:    r = {1'b0, a & b};
            4'd9:    r = {1'b0, a | b};
            4'd10:   r = {1'b0, a ^ b};
            4'd11:   r = {1'b0, ~a};
            4'd12:   r = {1'b0, ~(a & b)};
            4'd13:   r = {1'b0, ~(a | b)};
            4'd14:   r = {1'b0, ~(a ^ b)};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    // Expected {c_out, out} of operation op for the ALU wired to the selected instance.
    function automatic logic [8:0] exp_res(input logic s, input logic [7:0] a, input logic [7:0] b,
                                           input logic c, input logic [3:0] op);
        if (s) return alu_ref(a, b, c, op);
        return {c ^ op[0], a ^ {4'h0, op}};
    endfunction

    assign aout0    = a0 ^ {4'h0, mode0, ctrl0};
    assign cin_ret0 = cin0 ^ ctrl0[0];
    always_comb {cin_ret1, aout1} = alu_ref(a1, b1, cin1, {mode1, ctrl1});

    assign start0 = st & ~sel;
    assign start1 = st & sel;
    assign ready0 = sel ? 1'b1 : rdy;
    assign ready1 = sel ? rdy : 1'b1;

    alu_sweep_sequencer #(.WIDTH(8), .HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .alu_a(a0), .alu_b(b0), .alu_c_in(cin0), .alu_control_line(ctrl0),
        .alu_mode_select(mode0), .alu_out(aout0), .alu_c_out(cin_ret0),
        .res_valid(valid0), .res_ready(ready0), .res_index(idx0), .res_data(data0),
        .res_cout(cout0), .busy(busy0), .done(done0)
    );

    alu_sweep_sequencer #(.WIDTH(8), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .alu_a(a1), .alu_b(b1), .alu_c_in(cin1), .alu_control_line(ctrl1),
        .alu_mode_select(mode1), .alu_out(aout1), .alu_c_out(cin_ret1),
        .res_valid(valid1), .res_ready(ready1), .res_index(idx1), .res_data(data1),
        .res_cout(cout1), .busy(busy1), .done(done1)
    );

    logic [36:0] outs0, outs1;
    assign outs0 = {a0, b0, cin0, ctrl0, mode0, valid0, idx0, data0, cout0, busy0, done0};
    assign outs1 = {a1, b1, cin1, ctrl1, mode1, valid1, idx1, data1, cout1, busy1, done1};

    logic       m_valid, m_busy, m_done, m_cout, m_mode;
    logic [3:0] m_idx;
    logic [7:0] m_data, m_a;
    logic [2:0] m_ctrl;
    always_comb begin
        m_valid = sel ? valid1 : valid0;
        m_busy  = sel ? busy1  : busy0;
        m_done  = sel ? done1  : done0;
        m_cout  = sel ? cout1  : cout0;
        m_mode  = sel ? mode1  : mode0;
        m_idx   = sel ? idx1   : idx0;
        m_data  = sel ? data1  : data0;
        m_a     = sel ? a1     : a0;
        m_ctrl  = sel ? ctrl1  : ctrl0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // rmode: 0 ready tied high, 1 random ready, 2 ten-cycle stall on index 3.
    // restart_k: re-pulse start with op_a=FF during operation restart_k.
    // reset_k: pulse rst_n while in DRIVE at operation reset_k and abandon the sweep.
    task automatic run_sweep(input logic s, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input int rmode, input int restart_k,
                             input int reset_k, input logic start_in_done);
        int         k, since, total, stalls, hold;
        logic       pend, prev_valid, prev_ready;
        logic [3:0] prev_idx;
        logic [7:0] prev_data;
        logic [8:0] e;
        hold = s ? 1 : 4;
        k = 0; since = -1; total = -1; stalls = 0;
        pend = 1'b0; prev_valid = 1'b0; prev_ready = 1'b1; prev_idx = '0; prev_data = '0;
        @(negedge clk);
        sel = s; op_a = a; op_b = b; op_cin = c; rdy = 1'b1; st = 1'b1;
        forever begin
            @(posedge clk);
            if (pend) begin
                since = 0;
                pend  = 1'b0;
                k++;
            end else begin
                since++;
            end
            total++;
            @(negedge clk);
            st = 1'b0;
            if (k == 16) break;
            if (total > 3000) begin
                check_eq("timeout", 64'(total), 64'd0);
                return;
            end
            if (k == reset_k && since == 2) begin
                rst_n = 1'b0;
                #1;
                check_eq("reset_outs", {27'd0, outs0}, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("reset_no_done", {62'd0, m_done, m_busy}, 64'd0);
                end
                return;
            end
            if (k == restart_k && since == 1) begin
                op_a = 8'hFF;
                st   = 1'b1;
            end
            check_eq("busy_mid", 64'(m_busy), 64'd1);
            check_eq("done_mid", 64'(m_done), 64'd0);
            if (prev_valid && !prev_ready) begin
                check_eq("hold_valid", 64'(m_valid), 64'd1);
                check_eq("hold_index", 64'(m_idx), 64'(prev_idx));
                check_eq("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && !prev_valid) check_eq("settle", 64'(since), 64'(hold));
            if (m_valid) begin
                e = exp_res(s, a, b, c, 4'(k));
                check_eq("res_index", 64'(m_idx), 64'(k));
                check_eq("res_data", 64'(m_data), 64'(e[7:0]));
                check_eq("res_cout", 64'(m_cout), 64'(e[8]));
                check_eq("alu_a", 64'(m_a), 64'(a));
                check_eq("alu_op", 64'({m_mode, m_ctrl}), 64'(k));
            end
            case (rmode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = !(m_valid && k == 3 && stalls < 10);
                default: rdy = 1'b1;
            endcase
            if (m_valid && !rdy) stalls++;
            if (m_valid && rdy) pend = 1'b1;
            prev_valid = m_valid;
            prev_ready = rdy;
            prev_idx   = m_idx;
            prev_data  = m_data;
        end
        check_eq("sweep_cycles", 64'(total), 64'(16 * (hold + 1) + stalls));
        check_eq("done_pulse", {61'd0, m_done, m_busy, m_valid}, 64'h4);
        if (start_in_done) begin
            op_a = 8'hFF;
            st   = 1'b1;
        end
        rdy = 1'b1;
        @(negedge clk);
        st = 1'b0;
        check_eq("after_done", {61'd0, m_done, m_busy, m_valid}, 64'd0);
        if (rmode == 2) check_eq("stall_len", 64'(stalls), 64'd10);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; st = 1'b0; rdy = 1'b1; sel = 1'b0;
        op_a = 8'h00; op_b = 8'h00; op_cin = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_dut0", {27'd0, outs0}, 64'd0);
        check_eq("reset_dut1", {27'd0, outs1}, 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("idle_dut0", {27'd0, outs0}, 64'd0);
        check_eq("idle_dut1", {27'd0, outs1}, 64'd0);

        run_sweep(1'b0, 8'h02, 8'h03, 1'b0, 0, -1, -1, 1'b0);
        run_sweep(1'b0, 8'h02, 8'h03, 1'b0, 2, -1, -1, 1'b0);
        run_sweep(1'b0, 8'h02, 8'h03, 1'b0, 0, 7, -1, 1'b1);
        run_sweep(1'b0, 8'hFF, 8'h03, 1'b0, 0, -1, -1, 1'b0);
        run_sweep(1'b0, 8'h02, 8'h03, 1'b0, 0, -1, 9, 1'b0);
        run_sweep(1'b0, 8'h02, 8'h03, 1'b0, 0, -1, -1, 1'b0);
        run_sweep(1'b1, 8'd2, 8'd3, 1'b0, 0, -1, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_sweep(1'(i), 8'($urandom), 8'($urandom), 1'($urandom), 1, -1, -1, 1'(i >> 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
